// File: rtl/arbitro_memoria.sv
// Single-port data-memory arbiter between the CPU load/store path and the UART loader.
// One transaction at a time; the CPU has fixed priority, and an aging counter bounds how long the UART waits.
module arbitro_memoria #(
   parameter int ADDR_W      = 10,
   parameter int DATA_W      = 32,
   parameter int LAT_LEITURA = 1,
   parameter int MAX_ESPERA  = 8
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [1:0]        cpu_memoria,
   input  logic [ADDR_W-1:0] cpu_endereco,
   input  logic [DATA_W-1:0] cpu_dado_escrita,
   output logic [DATA_W-1:0] cpu_dado_leitura,
   output logic              cpu_stall,
   output logic              erro_cpu,
   input  logic              uart_req,
   input  logic              uart_we,
   input  logic [ADDR_W-1:0] uart_endereco,
   input  logic [DATA_W-1:0] uart_dado_escrita,
   output logic              uart_ack,
   output logic [DATA_W-1:0] uart_dado_leitura,
   output logic [ADDR_W-1:0] mem_endereco,
   output logic [DATA_W-1:0] mem_dado_escrita,
   output logic              mem_we,
   output logic              mem_re,
   input  logic [DATA_W-1:0] mem_dado_leitura
);

   localparam int ESP_W = $clog2(MAX_ESPERA + 1);
   localparam int LAT_W = $clog2(LAT_LEITURA + 1);
   localparam logic [ESP_W-1:0] ESP_MAX = ESP_W'(MAX_ESPERA);
   localparam logic [LAT_W-1:0] LAT_FIM = LAT_W'(LAT_LEITURA - 1);

   typedef enum logic [1:0] {OCIOSO, EMITIR, ESPERA, CONCLUIR} estado_t;
   typedef enum logic {DONO_CPU, DONO_UART} dono_t;

   estado_t           estado_q, estado_d;
   dono_t             dono_q, dono_d;
   logic              escrita_q, escrita_d;
   logic [ADDR_W-1:0] mem_endereco_q, mem_endereco_d;
   logic [DATA_W-1:0] mem_dado_escrita_q, mem_dado_escrita_d;
   logic              mem_we_q, mem_we_d;
   logic              mem_re_q, mem_re_d;
   logic [LAT_W-1:0]  lat_q, lat_d;
   logic [ESP_W-1:0]  espera_q, espera_d;
   logic              erro_q, erro_d;
   logic [DATA_W-1:0] cpu_rd_q, cpu_rd_d;
   logic [DATA_W-1:0] uart_rd_q, uart_rd_d;

   logic cpu_req, uart_vence, grant_cpu, grant_uart;

   assign cpu_req    = (cpu_memoria == 2'b01) || (cpu_memoria == 2'b10);
   assign uart_vence = uart_req && (espera_q == ESP_MAX);
   assign grant_cpu  = (estado_q == OCIOSO) && cpu_req && !uart_vence;
   assign grant_uart = (estado_q == OCIOSO) && uart_req && !grant_cpu;

   // NOTE: every signal gets its hold value first, so no path through the case leaves one unassigned (no latch).
   always_comb begin
      estado_d           = estado_q;
      dono_d             = dono_q;
      escrita_d          = escrita_q;
      mem_endereco_d     = mem_endereco_q;
      mem_dado_escrita_d = mem_dado_escrita_q;
      mem_we_d           = 1'b0;
      mem_re_d           = 1'b0;
      lat_d              = lat_q;
      cpu_rd_d           = cpu_rd_q;
      uart_rd_d          = uart_rd_q;
      erro_d             = erro_q | (cpu_memoria == 2'b11);

      unique case (estado_q)
         OCIOSO: begin
            // Strobes are set here so they are registered and high for exactly the EMITIR cycle.
            if (grant_cpu) begin
               dono_d             = DONO_CPU;
               escrita_d          = (cpu_memoria == 2'b10);
               mem_endereco_d     = cpu_endereco;
               mem_dado_escrita_d = cpu_dado_escrita;
               mem_we_d           = (cpu_memoria == 2'b10);
               mem_re_d           = (cpu_memoria == 2'b01);
               estado_d           = EMITIR;
            end else if (grant_uart) begin
               dono_d             = DONO_UART;
               escrita_d          = uart_we;
               mem_endereco_d     = uart_endereco;
               mem_dado_escrita_d = uart_dado_escrita;
               mem_we_d           = uart_we;
               mem_re_d           = !uart_we;
               estado_d           = EMITIR;
            end
         end
         EMITIR: begin
            lat_d    = '0;
            estado_d = escrita_q ? CONCLUIR : ESPERA;
         end
         ESPERA: begin
            if (lat_q == LAT_FIM) begin
               if (dono_q == DONO_CPU) cpu_rd_d = mem_dado_leitura;
               else                    uart_rd_d = mem_dado_leitura;
               estado_d = CONCLUIR;
            end else begin
               lat_d = lat_q + LAT_W'(1);
            end
         end
         CONCLUIR: estado_d = OCIOSO;
         default:  estado_d = OCIOSO;
      endcase

      // Aging: UART waiting time, frozen while its own transaction is in flight.
      if (!uart_req || grant_uart)
         espera_d = '0;
      else if ((estado_q != OCIOSO) && (dono_q == DONO_UART))
         espera_d = espera_q;
      else if (espera_q != ESP_MAX)
         espera_d = espera_q + ESP_W'(1);
      else
         espera_d = espera_q;
   end

   // NOTE: state registers use non-blocking assignments so all flops sample the same pre-edge values.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         estado_q           <= OCIOSO;
         dono_q             <= DONO_CPU;
         escrita_q          <= 1'b0;
         mem_endereco_q     <= '0;
         mem_dado_escrita_q <= '0;
         mem_we_q           <= 1'b0;
         mem_re_q           <= 1'b0;
         lat_q              <= '0;
         espera_q           <= '0;
         erro_q             <= 1'b0;
         cpu_rd_q           <= '0;
         uart_rd_q          <= '0;
      end else begin
         estado_q           <= estado_d;
         dono_q             <= dono_d;
         escrita_q          <= escrita_d;
         mem_endereco_q     <= mem_endereco_d;
         mem_dado_escrita_q <= mem_dado_escrita_d;
         mem_we_q           <= mem_we_d;
         mem_re_q           <= mem_re_d;
         lat_q              <= lat_d;
         espera_q           <= espera_d;
         erro_q             <= erro_d;
         cpu_rd_q           <= cpu_rd_d;
         uart_rd_q          <= uart_rd_d;
      end
   end

   assign mem_endereco      = mem_endereco_q;
   assign mem_dado_escrita  = mem_dado_escrita_q;
   assign mem_we            = mem_we_q;
   assign mem_re            = mem_re_q;
   assign cpu_dado_leitura  = cpu_rd_q;
   assign uart_dado_leitura = uart_rd_q;
   assign erro_cpu          = erro_q;
   assign uart_ack          = (estado_q == CONCLUIR) && (dono_q == DONO_UART);
   assign cpu_stall         = cpu_req && !((estado_q == CONCLUIR) && (dono_q == DONO_CPU));

endmodule

// File: tb/tb_arbitro_memoria.sv
// Directed bench for arbitro_memoria: one instance with LAT_LEITURA=1 on a behavioural RAM,
// and a second with LAT_LEITURA=3 on a pattern-returning RAM for the latency check.
module tb_arbitro_memoria;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;

   logic [1:0]  cpu_memoria = 2'b00;
   logic [9:0]  cpu_endereco = '0;
   logic [31:0] cpu_dado_escrita = '0;
   logic [31:0] cpu_dado_leitura;
   logic        cpu_stall, erro_cpu;
   logic        uart_req = 1'b0, uart_we = 1'b0;
   logic [9:0]  uart_endereco = '0;
   logic [31:0] uart_dado_escrita = '0;
   logic        uart_ack;
   logic [31:0] uart_dado_leitura;
   logic [9:0]  mem_endereco;
   logic [31:0] mem_dado_escrita;
   logic        mem_we, mem_re;
   logic [31:0] mem_dado_leitura;

   logic [1:0]  d3_cpu_memoria = 2'b00;
   logic [9:0]  d3_cpu_endereco = '0;
   logic [31:0] d3_cpu_dado_leitura;
   logic        d3_cpu_stall, d3_erro_cpu, d3_uart_ack;
   logic [31:0] d3_uart_dado_leitura;
   logic [9:0]  d3_mem_endereco;
   logic [31:0] d3_mem_dado_escrita;
   logic        d3_mem_we, d3_mem_re;
   logic [31:0] d3_mem_dado_leitura;

   int total = 0;
   int bad = 0;

   always #5 clock = ~clock;

   arbitro_memoria #(.ADDR_W(10), .DATA_W(32), .LAT_LEITURA(1), .MAX_ESPERA(8)) dut (
      .clock(clock), .reset_n(reset_n),
      .cpu_memoria(cpu_memoria), .cpu_endereco(cpu_endereco), .cpu_dado_escrita(cpu_dado_escrita),
      .cpu_dado_leitura(cpu_dado_leitura), .cpu_stall(cpu_stall), .erro_cpu(erro_cpu),
      .uart_req(uart_req), .uart_we(uart_we), .uart_endereco(uart_endereco),
      .uart_dado_escrita(uart_dado_escrita), .uart_ack(uart_ack), .uart_dado_leitura(uart_dado_leitura),
      .mem_endereco(mem_endereco), .mem_dado_escrita(mem_dado_escrita),
      .mem_we(mem_we), .mem_re(mem_re), .mem_dado_leitura(mem_dado_leitura)
   );

   arbitro_memoria #(.ADDR_W(10), .DATA_W(32), .LAT_LEITURA(3), .MAX_ESPERA(8)) dut3 (
      .clock(clock), .reset_n(reset_n),
      .cpu_memoria(d3_cpu_memoria), .cpu_endereco(d3_cpu_endereco), .cpu_dado_escrita(32'h0),
      .cpu_dado_leitura(d3_cpu_dado_leitura), .cpu_stall(d3_cpu_stall), .erro_cpu(d3_erro_cpu),
      .uart_req(1'b0), .uart_we(1'b0), .uart_endereco(10'h0),
      .uart_dado_escrita(32'h0), .uart_ack(d3_uart_ack), .uart_dado_leitura(d3_uart_dado_leitura),
      .mem_endereco(d3_mem_endereco), .mem_dado_escrita(d3_mem_dado_escrita),
      .mem_we(d3_mem_we), .mem_re(d3_mem_re), .mem_dado_leitura(d3_mem_dado_leitura)
   );

   // Synchronous RAM, one-cycle read latency; output is zero when not reading so a mistimed capture shows.
   logic [31:0] ram [0:1023];
   logic [31:0] ram_q = '0;
   always @(posedge clock) begin
      if (mem_we) ram[mem_endereco] <= mem_dado_escrita;
      ram_q <= mem_re ? ram[mem_endereco] : 32'h0;
   end
   assign mem_dado_leitura = ram_q;

   // Three-cycle RAM returning C0DE0000 | address.
   logic [31:0] p3 [3];
   initial for (int i = 0; i < 3; i++) p3[i] = '0;
   always @(posedge clock) begin
      p3[0] <= d3_mem_re ? (32'hC0DE0000 | 32'(d3_mem_endereco)) : 32'h0;
      p3[1] <= p3[0];
      p3[2] <= p3[1];
   end
   assign d3_mem_dado_leitura = p3[2];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Start a new cycle: inputs are driven 1 time unit after the rising edge.
   task automatic ciclo();
      @(posedge clock);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int ack_cycle, we_cycle, cpu_done, lat;
      logic ack_seen, stall_at_ack;

      // Reset values
      #12;
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_re", mem_re, 0);
      check("rst_ack", uart_ack, 0);
      check("rst_erro", erro_cpu, 0);
      check("rst_stall", cpu_stall, 0);
      check("rst_addr", mem_endereco, 0);
      check("rst_cpu_rd", cpu_dado_leitura, 0);
      ciclo();
      reset_n = 1'b1;
      ciclo();

      // 1: CPU store then load
      ciclo(); cpu_memoria = 2'b10; cpu_endereco = 10'h005; cpu_dado_escrita = 32'hDEADBEEF;
      @(negedge clock); check("t1_sw_c0_stall", cpu_stall, 1); check("t1_sw_c0_we", mem_we, 0);
      ciclo(); @(negedge clock);
      check("t1_sw_c1_we", mem_we, 1); check("t1_sw_c1_addr", mem_endereco, 10'h005);
      check("t1_sw_c1_data", mem_dado_escrita, 32'hDEADBEEF); check("t1_sw_c1_stall", cpu_stall, 1);
      ciclo(); @(negedge clock); check("t1_sw_c2_stall", cpu_stall, 0);
      ciclo(); cpu_memoria = 2'b01;
      @(negedge clock); check("t1_lw_c0_stall", cpu_stall, 1);
      ciclo(); @(negedge clock); check("t1_lw_c1_re", mem_re, 1); check("t1_lw_c1_we", mem_we, 0);
      ciclo(); @(negedge clock); check("t1_lw_c2_stall", cpu_stall, 1);
      ciclo(); @(negedge clock);
      check("t1_lw_c3_stall", cpu_stall, 0); check("t1_lw_data", cpu_dado_leitura, 32'hDEADBEEF);
      ciclo(); cpu_memoria = 2'b00;
      @(negedge clock); check("t1_idle_re", mem_re, 0);

      // 2: UART write then read of the top address
      ciclo(); uart_req = 1'b1; uart_we = 1'b1; uart_endereco = 10'h3FF; uart_dado_escrita = 32'h12345678;
      @(negedge clock); check("t2_w_c0_ack", uart_ack, 0);
      ciclo(); @(negedge clock);
      check("t2_w_c1_we", mem_we, 1); check("t2_w_c1_addr", mem_endereco, 10'h3FF); check("t2_w_c1_ack", uart_ack, 0);
      ciclo(); @(negedge clock); check("t2_w_c2_ack", uart_ack, 1);
      ciclo(); uart_we = 1'b0;
      @(negedge clock); check("t2_r_c0_ack", uart_ack, 0);
      ciclo(); @(negedge clock); check("t2_r_c1_re", mem_re, 1); check("t2_r_c1_ack", uart_ack, 0);
      ciclo(); @(negedge clock); check("t2_r_c2_ack", uart_ack, 0);
      ciclo(); @(negedge clock);
      check("t2_r_c3_ack", uart_ack, 1); check("t2_r_data", uart_dado_leitura, 32'h12345678);
      ciclo(); uart_req = 1'b0;
      @(negedge clock); check("t2_ack_single", uart_ack, 0);

      // 3: CPU writes every cycle against a held UART write; aging must let the UART in
      ciclo();
      cpu_memoria = 2'b10; cpu_endereco = 10'h010; cpu_dado_escrita = 32'h00001111;
      uart_req = 1'b1; uart_we = 1'b1; uart_endereco = 10'h020; uart_dado_escrita = 32'h0000AAAA;
      ack_cycle = -1; we_cycle = -1; cpu_done = 0; ack_seen = 1'b0; stall_at_ack = 1'b0;
      for (int k = 0; k < 30 && !ack_seen; k++) begin
         if (k > 0) ciclo();
         @(negedge clock);
         if (mem_we && mem_endereco == 10'h020) we_cycle = k;
         if (!cpu_stall) cpu_done++;
         if (uart_ack) begin ack_cycle = k; ack_seen = 1'b1; stall_at_ack = cpu_stall; end
      end
      check("t3_uart_we_cycle", 64'(we_cycle), 64'd10);
      check("t3_uart_ack_cycle", 64'(ack_cycle), 64'd11);
      check("t3_cpu_done_before", 64'(cpu_done), 64'd3);
      check("t3_stall_at_ack", stall_at_ack, 1);
      ciclo(); uart_req = 1'b0;
      @(negedge clock); check("t3_c12_stall", cpu_stall, 1);
      ciclo(); @(negedge clock); check("t3_c13_cpu_we", mem_we, 1); check("t3_c13_cpu_addr", mem_endereco, 10'h010);
      ciclo(); @(negedge clock); check("t3_c14_stall", cpu_stall, 0);
      ciclo(); cpu_memoria = 2'b00;
      @(negedge clock);

      // 4: simultaneous reads, counter at zero: CPU first, then UART
      ciclo();
      cpu_memoria = 2'b01; cpu_endereco = 10'h005;
      uart_req = 1'b1; uart_we = 1'b0; uart_endereco = 10'h3FF;
      @(negedge clock); check("t4_c0_stall", cpu_stall, 1);
      ciclo(); @(negedge clock); check("t4_c1_re", mem_re, 1); check("t4_c1_addr", mem_endereco, 10'h005);
      ciclo(); @(negedge clock);
      ciclo(); @(negedge clock);
      check("t4_c3_stall", cpu_stall, 0); check("t4_cpu_data", cpu_dado_leitura, 32'hDEADBEEF); check("t4_c3_ack", uart_ack, 0);
      ciclo(); cpu_memoria = 2'b00;
      @(negedge clock); check("t4_c4_ack", uart_ack, 0);
      ciclo(); @(negedge clock); check("t4_c5_re", mem_re, 1); check("t4_c5_addr", mem_endereco, 10'h3FF);
      ciclo(); @(negedge clock);
      ciclo(); @(negedge clock);
      check("t4_c7_ack", uart_ack, 1); check("t4_uart_data", uart_dado_leitura, 32'h12345678);
      ciclo(); uart_req = 1'b0;
      @(negedge clock); check("t4_c8_ack", uart_ack, 0);

      // 6a: illegal CPU code
      ciclo(); cpu_memoria = 2'b11;
      @(negedge clock); check("t6_c0_stall", cpu_stall, 0); check("t6_c0_strobe", {mem_we, mem_re}, 2'b00);
      ciclo(); cpu_memoria = 2'b00;
      @(negedge clock); check("t6_c1_erro", erro_cpu, 1); check("t6_c1_strobe", {mem_we, mem_re}, 2'b00);
      ciclo(); @(negedge clock); check("t6_c2_erro_sticky", erro_cpu, 1); check("t6_c2_strobe", {mem_we, mem_re}, 2'b00);

      // 5: reset during ESPERA of a UART read
      ciclo(); uart_req = 1'b1; uart_we = 1'b0; uart_endereco = 10'h3FF;
      @(negedge clock);
      ciclo(); @(negedge clock); check("t5_c1_re", mem_re, 1);
      ciclo(); @(negedge clock);
      reset_n = 1'b0; uart_req = 1'b0;
      #1;
      check("t5_rst_re", mem_re, 0); check("t5_rst_ack", uart_ack, 0);
      check("t5_rst_uart_rd", uart_dado_leitura, 0); check("t5_rst_erro", erro_cpu, 0);
      ciclo(); ciclo();
      reset_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         ciclo(); @(negedge clock);
         check("t5_no_ack_after", uart_ack, 0);
      end
      ciclo(); cpu_memoria = 2'b01; cpu_endereco = 10'h005;
      @(negedge clock); check("t5_lw_c0_stall", cpu_stall, 1);
      ciclo(); @(negedge clock); check("t5_lw_c1_re", mem_re, 1);
      ciclo(); @(negedge clock); check("t5_lw_c2_stall", cpu_stall, 1);
      ciclo(); @(negedge clock);
      check("t5_lw_c3_stall", cpu_stall, 0); check("t5_lw_data", cpu_dado_leitura, 32'hDEADBEEF);
      ciclo(); cpu_memoria = 2'b00;
      @(negedge clock);

      // 6b: LAT_LEITURA=3 read latency
      ciclo(); d3_cpu_memoria = 2'b01; d3_cpu_endereco = 10'h123;
      lat = -1;
      for (int k = 0; k < 20 && lat < 0; k++) begin
         if (k > 0) ciclo();
         @(negedge clock);
         if (k == 1) check("t6b_c1_re", d3_mem_re, 1);
         if (!d3_cpu_stall) lat = k;
      end
      check("t6b_latency", 64'(lat), 64'd5);
      check("t6b_data", d3_cpu_dado_leitura, 32'hC0DE0123);
      ciclo(); d3_cpu_memoria = 2'b00;
      @(negedge clock); check("t6b_idle_stall", d3_cpu_stall, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
